nou_w_data_fifo: RTL and testbench

NOU_W_DATA_FIFO -- requirements
Module: nou_w_data_fifo

---
 rtl/nou_w_data_fifo_pkg.sv | 12 +
 rtl/nou_w_fifo_mem.sv | 25 ++
 rtl/nou_w_data_fifo.sv | 66 ++++++
 tb/tb_nou_w_data_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nou_w_data_fifo_pkg.sv
// Shared widths and defaults for the NoC W-data FIFO.
`ifndef NOU_NOC_DATA_WIDTH
`define NOU_NOC_DATA_WIDTH 64
`endif
`ifndef NOU_W_FIFO_DEPTH
`define NOU_W_FIFO_DEPTH 16
`endif

package nou_w_data_fifo_pkg;
   localparam int NOC_DW       = `NOU_NOC_DATA_WIDTH;
   localparam int W_FIFO_DEPTH = `NOU_W_FIFO_DEPTH;
endpackage

// File: rtl/nou_w_fifo_mem.sv
// Register-array storage: one synchronous write port, one async read port.
// Not reset, so contents are don't-care until written.
module nou_w_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int W     = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/nou_w_data_fifo.sv
// Show-ahead FIFO buffering NoC write-data flits for the AXI W master.
// Pointer, occupancy and flag logic live here; storage is nou_w_fifo_mem.
module nou_w_data_fifo
   import nou_w_data_fifo_pkg::*;
#(
   parameter int DEPTH     = W_FIFO_DEPTH,
   parameter int AFULL_LVL = 14,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [NOC_DW-1:0] wr_data,
   output logic              full,
   output logic              afull,
   output logic [NOC_DW-1:0] data,
   output logic              empty,
   input  logic              rd_en,
   output logic [CW-1:0]     count,
   output logic              ovf_err
);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   // Flags decode only from the registered count.
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign afull = (count >= CW'(AFULL_LVL));

   // Full blocks a push even if a pop happens the same cycle; empty blocks
   // pops, so rd_en can be driven straight from the AXI ready.
   assign push = wr_en & ~full;
   assign pop  = rd_en & ~empty;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (wr_en && full) ovf_err <= 1'b1;
      end
   end

   nou_w_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (NOC_DW),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (data)
   );

endmodule

// File: tb/tb_nou_w_data_fifo.sv
// Directed + scoreboard bench for nou_w_data_fifo (DEPTH=16, AFULL_LVL=14).
module tb_nou_w_data_fifo;
   import nou_w_data_fifo_pkg::*;

   localparam int DEPTH = 16;
   localparam int AFL   = 14;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic              rd_en = 1'b0;
   logic [NOC_DW-1:0] wr_data = '0;
   logic              full, afull, empty, ovf_err;
   logic [NOC_DW-1:0] data;
   logic [4:0]        count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   nou_w_data_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFL)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .afull(afull), .data(data), .empty(empty),
      .rd_en(rd_en), .count(count), .ovf_err(ovf_err)
   );

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_en = 0; rd_en = 0; rst_n = 0;
      tick(); tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      wr_en = 0; rd_en = 0; rst_n = 0;
      tick(); tick();
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0 || ovf_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: count=%0d empty=%b full=%b afull=%b ovf=%b, want 0 1 0 0 0",
                  count, empty, full, afull, ovf_err);
      end
      rst_n = 1;
   endtask

   task automatic test_push4();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         wr_en = 1; wr_data = NOC_DW'(i);
         tick();
         if (i == 1) begin
            n_checks++;
            if (empty !== 1'b0 || data !== NOC_DW'(1)) begin
               n_fail++;
               $display("FAIL first_push_latency: empty=%b data=%0h, want 0 1", empty, data);
            end
         end
      end
      wr_en = 0;
      n_checks++;
      if (count !== 5'd4 || data !== NOC_DW'(1) || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL push4: count=%0d data=%0h empty=%b, want 4 1 0", count, data, empty);
      end
   endtask

   task automatic test_rd_while_empty();
      int bad = 0;
      do_reset();
      rd_en = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (count !== 5'd0 || empty !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rd_while_empty: %0d bad cycles, last count=%0d empty=%b, want 0 1", bad, count, empty);
      end
      wr_en = 1; wr_data = NOC_DW'('hA);
      tick();
      wr_en = 0;
      n_checks++;
      if (count !== 5'd1 || data !== NOC_DW'('hA) || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL push_rd_empty: count=%0d data=%0h empty=%b, want 1 a 0", count, data, empty);
      end
      tick();
      rd_en = 0;
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL pop_after_push: count=%0d empty=%b, want 0 1", count, empty);
      end
   endtask

   task automatic test_full_ovf();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1; wr_data = NOC_DW'('h100 + i);
         tick();
         if (i == AFL - 2 || i == AFL - 1) begin
            n_checks++;
            if (afull !== (i == AFL - 1)) begin
               n_fail++;
               $display("FAIL afull_edge: count=%0d afull=%b, want %b", count, afull, (i == AFL - 1));
            end
         end
      end
      n_checks++;
      if (count !== 5'd16 || full !== 1'b1 || afull !== 1'b1 || ovf_err !== 1'b0) begin
         n_fail++;
         $display("FAIL fill16: count=%0d full=%b afull=%b ovf=%b, want 16 1 1 0", count, full, afull, ovf_err);
      end
      wr_data = NOC_DW'('hDEAD); rd_en = 1;
      tick();
      wr_en = 0;
      n_checks++;
      if (count !== 5'd15 || ovf_err !== 1'b1 || full !== 1'b0 || data !== NOC_DW'('h101)) begin
         n_fail++;
         $display("FAIL ovf_push: count=%0d ovf=%b full=%b data=%0h, want 15 1 0 101", count, ovf_err, full, data);
      end
      for (int i = 1; i < DEPTH; i++) begin
         n_checks++;
         if (data !== NOC_DW'('h100 + i)) begin
            n_fail++;
            $display("FAIL drain_order: data=%0h, want %0h", data, 'h100 + i);
         end
         tick();
      end
      rd_en = 0;
      n_checks++;
      if (empty !== 1'b1 || count !== 5'd0 || ovf_err !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_end: empty=%b count=%0d ovf=%b, want 1 0 1", empty, count, ovf_err);
      end
   endtask

   task automatic test_stream();
      int bad_d = 0, bad_c = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_en = 1; wr_data = NOC_DW'(i);
         tick();
      end
      rd_en = 1;
      for (int i = 0; i < 100; i++) begin
         wr_data = NOC_DW'(3 + i);
         if (data !== NOC_DW'(i)) bad_d++;
         tick();
         if (count !== 5'd3) bad_c++;
      end
      wr_en = 0; rd_en = 0;
      n_checks++;
      if (bad_d != 0) begin
         n_fail++;
         $display("FAIL stream_order: %0d head mismatches, want 0", bad_d);
      end
      n_checks++;
      if (bad_c != 0) begin
         n_fail++;
         $display("FAIL stream_count: %0d cycles count!=3, last count=%0d", bad_c, count);
      end
   endtask

   task automatic test_random();
      logic [NOC_DW-1:0] q[$];
      logic m_ovf = 1'b0;
      int fails0 = n_fail;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         logic w, r, p, o;
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         wr_en = w; rd_en = r; wr_data = {$urandom, $urandom};
         #1;
         if (q.size() > 0) begin
            n_checks++;
            if (data !== q[0]) begin
               n_fail++;
               if (n_fail - fails0 < 10) $display("FAIL rand_data: cycle %0d data=%0h, want %0h", c, data, q[0]);
            end
         end
         n_checks++;
         if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || afull !== (q.size() >= AFL)) begin
            n_fail++;
            if (n_fail - fails0 < 10) $display("FAIL rand_flags: cycle %0d e/f/af=%b%b%b, model size %0d", c, empty, full, afull, q.size());
         end
         p = w && (q.size() < DEPTH);
         o = r && (q.size() > 0);
         if (w && q.size() == DEPTH) m_ovf = 1'b1;
         if (o) void'(q.pop_front());
         if (p) q.push_back(wr_data);
         tick();
         n_checks++;
         if (count !== 5'(q.size()) || ovf_err !== m_ovf) begin
            n_fail++;
            if (n_fail - fails0 < 10) $display("FAIL rand_count: cycle %0d count=%0d ovf=%b, want %0d %b", c, count, ovf_err, q.size(), m_ovf);
         end
      end
      wr_en = 0; rd_en = 0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      wr_en = 1;
      for (int i = 0; i <= DEPTH; i++) begin
         wr_data = NOC_DW'('h200 + i);
         tick();
      end
      wr_en = 0; rd_en = 1;
      repeat (7) tick();
      rd_en = 0;
      n_checks++;
      if (count !== 5'd9 || ovf_err !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: count=%0d ovf=%b, want 9 1", count, ovf_err);
      end
      rst_n = 0;
      #1;
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1 || ovf_err !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: count=%0d empty=%b ovf=%b, want 0 1 0", count, empty, ovf_err);
      end
      tick();
      rst_n = 1;
      wr_en = 1; wr_data = NOC_DW'('h55);
      tick();
      wr_en = 0;
      n_checks++;
      if (count !== 5'd1 || data !== NOC_DW'('h55) || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_push: count=%0d data=%0h empty=%b, want 1 55 0", count, data, empty);
      end
   endtask

   initial begin
      test_reset();
      test_push4();
      test_rd_while_empty();
      test_full_ovf();
      test_stream();
      test_random();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
